retire_trace_writer: RTL and testbench
======================================

# retire_trace_writer

Synthesizable producer side of the pipeline debug trace. It shadows the five-stage WISC pipeline (IF/ID/EX/MEM/WB) with a valid/tag shift register under the same stall and flush controls as the CPU. It assigns a sequence tag to each fetched instruction and pushes one retirement record per completed instruction into a FIFO. A bench or on-chip consumer drains that FIFO through a ready/valid port.

## Interface
- TAG_W, 7: sequence tag width; tags wrap modulo 2^TAG_W.
- DEPTH, 8: trace FIFO entries, power of two, at least 2.
- CYC_W, 32: cycle counter width.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- fetch_pc  in  16  PC of the instruction currently in IF.
- fetch_instr  in  16  instruction word currently in IF.
- stall  in  1  load-use hazard: PC and IF/ID hold, ID/EX takes a bubble.
- if_flush  in  1  IF/ID takes a bubble (branch taken in ID).
- id_flush  in  1  ID/EX takes a bubble.
- trace_valid  out  1  FIFO non-empty.
- trace_ready  in  1  consumer accepts the head record.
- trace_tag  out  TAG_W  head record tag.
- trace_pc  out  16  head record PC.
- trace_instr  out  16  head record instruction word.
- trace_fetch_cycle  out  CYC_W  cycle in which the instruction was captured from IF.
- trace_wb_cycle  out  CYC_W  cycle in which the instruction occupied WB.
- fifo_count  out  $clog2(DEPTH)+1  number of occupied entries.
- overflow_cnt  out  16  dropped records, saturating at 0xFFFF.

## Operation
- Stage registers D, X, M, W each hold {valid, tag, pc, instr, fetch_cycle}.
- Each edge updates the stages as follows:
  - W ← M and M ← X.
  - X ← bubble if stall or id_flush, else D.
  - D ← D if stall; else bubble if if_flush; else {1, tag_ctr, fetch_pc, fetch_instr, cyc}.
- stall together with if_flush: stall wins, so D holds.
- tag_ctr increments only when D captures a new fetch. Bubbles never consume a tag. The counter wraps from 2^TAG_W−1 to 0.
- cyc is a free-running counter: 0 in the first cycle after rst deasserts, +1 per cycle, wraps.
- Retirement: on every edge where W.valid=1, push {W.tag, W.pc, W.instr, W.fetch_cycle, cyc}.
- FIFO behaviour:
  - Pop when trace_valid && trace_ready.
  - When full, a push is accepted only if a pop occurs in the same cycle. Otherwise the record is dropped and overflow_cnt increments, saturating.
  - Read and write pointers wrap modulo DEPTH.
  - The head record is stable while trace_valid && !trace_ready.

## Timing
- Reset values: all stage valids 0, tag_ctr 0, cyc 0, FIFO empty, trace_valid 0, fifo_count 0, overflow_cnt 0. Record outputs are 0 when the FIFO is empty.
- Reset mid-operation discards all in-flight stages and FIFO contents. trace_valid reads 0 in the cycle after the rst edge.
- Unstalled latency, for a fetch captured at the end of cycle c:
  - D in c+1, X in c+2, M in c+3, W in c+4.
  - Record pushed at the end of c+4; trace_valid visible in c+5.
  - wb_cycle = fetch_cycle + 4.
- Each stall cycle while the instruction is in D adds 1 to wb_cycle − fetch_cycle.
- Push and pop in the same cycle leave fifo_count unchanged. On an empty FIFO this is impossible, because trace_valid is registered; there is no fall-through.
- At most one push and one pop occur per cycle.

## Structure
- Package trace_pkg holds:
  - trace_rec_t, a packed struct {tag, pc, instr, fetch_cycle, wb_cycle}.
  - stage_t, a packed struct {valid, tag, pc, instr, fetch_cycle}.
  - Default TAG_W and CYC_W localparams.
- Sub-module trace_fifo provides a parameterized synchronous FIFO of trace_rec_t with push/pop, full/empty, count and the drop-when-full rule. The top level holds the stage shift, tag counter and cycle counter.

## Test plan
- Straight line: reset, then 6 fetches at PC 0x0000, 0x0002, … 0x000A with trace_ready=1. Required: records with tags 0–5 in order, first trace_valid in cycle 5, every wb_cycle − fetch_cycle = 4.
- Stall: assert stall for 1 cycle while tag 2 is in D. Required: tags 0–5 remain consecutive, no extra record, tag 2 delta = 5, later tags delta = 4.
- Flush: if_flush for 1 cycle with PC 0x0006 in IF. Required: no record for 0x0006, and the next fetched PC receives the next consecutive tag. A separate case with stall and if_flush together: D holds and the held tag later retires.
- Backpressure: trace_ready=0, 12 straight instructions, DEPTH=8. Required: fifo_count=8, overflow_cnt=4. Raising trace_ready then drains tags 0–7 in order.
- Wrap: 130 instructions with TAG_W=7. Required: tag 127 is followed by tag 0, with no gap in PC order.
- Reset mid-run: rst asserted with 3 instructions in flight and 2 records queued. Required: trace_valid=0 in the next cycle, no discarded record ever appears, and tags restart at 0.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared types for the retirement trace: the per-stage shadow entry and the
// record that leaves the trace FIFO once an instruction has passed WB.
package trace_pkg;

  localparam int TRACE_TAG_W = 7;
  localparam int TRACE_CYC_W = 32;

  typedef struct packed {
    logic [TRACE_TAG_W-1:0] tag;
    logic [15:0]            pc;
    logic [15:0]            instr;
    logic [TRACE_CYC_W-1:0] fetch_cycle;
    logic [TRACE_CYC_W-1:0] wb_cycle;
  } trace_rec_t;

  typedef struct packed {
    logic                   valid;
    logic [TRACE_TAG_W-1:0] tag;
    logic [15:0]            pc;
    logic [15:0]            instr;
    logic [TRACE_CYC_W-1:0] fetch_cycle;
  } stage_t;

  function automatic trace_rec_t make_rec(input stage_t s, input logic [TRACE_CYC_W-1:0] wb);
    trace_rec_t r;
    r.tag         = s.tag;
    r.pc          = s.pc;
    r.instr       = s.instr;
    r.fetch_cycle = s.fetch_cycle;
    r.wb_cycle    = wb;
    return r;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO of trace records. A push into a full FIFO is only taken
// when a pop happens in the same cycle; otherwise it is dropped and counted.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  trace_rec_t      push_rec,
  input  logic            pop_ready,
  output logic            empty,
  output trace_rec_t      head_rec,
  output logic [AW:0]     count,
  output logic [15:0]     overflow_cnt
);

  localparam int CNT_W = AW + 1;

  trace_rec_t      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            full;
  logic            pop;
  logic            accept;
  logic            drop;

  assign empty  = (count == '0);
  assign full   = (count == CNT_W'(DEPTH));
  assign pop    = !empty && pop_ready;
  assign accept = push && (!full || pop);
  assign drop   = push && full && !pop;

  // No fall-through: a record written this cycle is visible only next cycle.
  assign head_rec = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= push_rec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow_cnt <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (accept && !pop) begin
        count <= count + 1'b1;
      end else if (!accept && pop) begin
        count <= count - 1'b1;
      end
      if (drop && overflow_cnt != 16'hFFFF) begin
        overflow_cnt <= overflow_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/retire_trace_writer.sv
// Shadows the five-stage pipeline with valid/tag stage registers and queues one
// trace record per retiring instruction. TAG_W/CYC_W must match trace_pkg.
module retire_trace_writer
  import trace_pkg::*;
#(
  parameter int TAG_W = TRACE_TAG_W,
  parameter int DEPTH = 8,
  parameter int CYC_W = TRACE_CYC_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [15:0]              fetch_pc,
  input  logic [15:0]              fetch_instr,
  input  logic                     stall,
  input  logic                     if_flush,
  input  logic                     id_flush,
  // Handshake: a record transfers on any cycle where trace_valid and
  // trace_ready are both high; the head holds while valid && !ready.
  output logic                     trace_valid,
  input  logic                     trace_ready,
  output logic [TAG_W-1:0]         trace_tag,
  output logic [15:0]              trace_pc,
  output logic [15:0]              trace_instr,
  output logic [CYC_W-1:0]         trace_fetch_cycle,
  output logic [CYC_W-1:0]         trace_wb_cycle,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [15:0]              overflow_cnt
);

  stage_t           d_q, x_q, m_q, w_q;
  stage_t           d_n, x_n;
  logic [TAG_W-1:0] tag_ctr;
  logic [CYC_W-1:0] cyc;
  logic             capture;
  logic             fifo_empty;
  trace_rec_t       head_rec;
  trace_rec_t       retire_rec;

  // Stall beats if_flush: D holds and the held instruction keeps its tag.
  assign capture = !stall && !if_flush;

  always_comb begin
    d_n = d_q;
    if (!stall) begin
      if (if_flush) begin
        d_n = '0;
      end else begin
        d_n = '{valid: 1'b1, tag: tag_ctr, pc: fetch_pc, instr: fetch_instr, fetch_cycle: cyc};
      end
    end
  end

  always_comb begin
    x_n = d_q;
    if (stall || id_flush) begin
      x_n = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_q     <= '0;
      x_q     <= '0;
      m_q     <= '0;
      w_q     <= '0;
      tag_ctr <= '0;
      cyc     <= '0;
    end else begin
      d_q <= d_n;
      x_q <= x_n;
      m_q <= x_q;
      w_q <= m_q;
      cyc <= cyc + 1'b1;
      if (capture) begin
        tag_ctr <= tag_ctr + 1'b1;
      end
    end
  end

  // The record is stamped with the cycle the instruction spends in WB.
  assign retire_rec = make_rec(w_q, cyc);

  trace_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push         (w_q.valid),
    .push_rec     (retire_rec),
    .pop_ready    (trace_ready),
    .empty        (fifo_empty),
    .head_rec     (head_rec),
    .count        (fifo_count),
    .overflow_cnt (overflow_cnt)
  );

  assign trace_valid       = !fifo_empty;
  assign trace_tag         = head_rec.tag;
  assign trace_pc          = head_rec.pc;
  assign trace_instr       = head_rec.instr;
  assign trace_fetch_cycle = head_rec.fetch_cycle;
  assign trace_wb_cycle    = head_rec.wb_cycle;

endmodule

// File: tb/tb_retire_trace_writer.sv
// Directed and randomized bench for retire_trace_writer against a reference
// that tracks only the ID slot and treats the rest of the pipe as a fixed delay.
module tb_retire_trace_writer;

  localparam int TAG_W = 7;
  localparam int DEPTH = 8;
  localparam int CYC_W = 32;
  localparam int REC_W = TAG_W + 16 + 16 + CYC_W + CYC_W;

  logic              clk = 1'b0;
  logic              rst;
  logic [15:0]       fetch_pc;
  logic [15:0]       fetch_instr;
  logic              stall;
  logic              if_flush;
  logic              id_flush;
  logic              trace_valid;
  logic              trace_ready;
  logic [TAG_W-1:0]  trace_tag;
  logic [15:0]       trace_pc;
  logic [15:0]       trace_instr;
  logic [CYC_W-1:0]  trace_fetch_cycle;
  logic [CYC_W-1:0]  trace_wb_cycle;
  logic [3:0]        fifo_count;
  logic [15:0]       overflow_cnt;

  retire_trace_writer #(.TAG_W(TAG_W), .DEPTH(DEPTH), .CYC_W(CYC_W)) dut (
    .clk               (clk),
    .rst               (rst),
    .fetch_pc          (fetch_pc),
    .fetch_instr       (fetch_instr),
    .stall             (stall),
    .if_flush          (if_flush),
    .id_flush          (id_flush),
    .trace_valid       (trace_valid),
    .trace_ready       (trace_ready),
    .trace_tag         (trace_tag),
    .trace_pc          (trace_pc),
    .trace_instr       (trace_instr),
    .trace_fetch_cycle (trace_fetch_cycle),
    .trace_wb_cycle    (trace_wb_cycle),
    .fifo_count        (fifo_count),
    .overflow_cnt      (overflow_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference state
  logic [REC_W-1:0] exp_q[$];
  logic [REC_W-1:0] pend_q[$];
  bit               d_valid;
  logic [TAG_W-1:0] d_tag;
  logic [15:0]      d_pc;
  logic [15:0]      d_instr;
  logic [31:0]      d_fc;
  logic [TAG_W-1:0] m_tag;
  logic [31:0]      m_cyc;
  int               m_ovf;
  logic [15:0]      pc_reg;

  // Observed pops
  int log_tag[$];
  int log_pc[$];
  int log_delta[$];
  int first_valid;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [REC_W-1:0] head;
    logic [REC_W-1:0] obs;
    head = (exp_q.size() > 0) ? exp_q[0] : '0;
    obs  = {trace_tag, trace_pc, trace_instr, trace_fetch_cycle, trace_wb_cycle};
    chk("trace_valid", 128'(trace_valid), 128'(exp_q.size() > 0));
    chk("head_record", 128'(obs), 128'(head));
    chk("fifo_count", 128'(fifo_count), 128'(exp_q.size()));
    chk("overflow_cnt", 128'(overflow_cnt), 128'(m_ovf));
    if (trace_valid === 1'b1 && first_valid < 0) first_valid = int'(m_cyc);
    if (trace_valid === 1'b1 && trace_ready === 1'b1) begin
      log_tag.push_back(int'(trace_tag));
      log_pc.push_back(int'(trace_pc));
      log_delta.push_back(int'(trace_wb_cycle - trace_fetch_cycle));
    end
  endtask

  // Advance the reference across one clock edge with the current inputs.
  task automatic model_edge(input bit st, input bit ifl, input bit idf, input bit rdy, input bit r);
    logic [REC_W-1:0] rec;
    bit pop;
    bit push;
    if (r) begin
      exp_q.delete();
      pend_q.delete();
      d_valid = 0;
      m_tag   = '0;
      m_cyc   = '0;
      m_ovf   = 0;
      return;
    end
    pop  = (exp_q.size() > 0) && rdy;
    push = 0;
    if (pend_q.size() > 0) begin
      rec  = pend_q[0];
      push = (rec[31:0] == m_cyc);
    end
    if (pop) void'(exp_q.pop_front());
    if (push) begin
      rec = pend_q.pop_front();
      if (exp_q.size() < DEPTH) exp_q.push_back(rec);
      else if (m_ovf < 65535) m_ovf++;
    end
    if (!st) begin
      // Leaving ID unflushed means retiring in WB exactly three cycles later.
      if (d_valid && !idf) pend_q.push_back({d_tag, d_pc, d_instr, d_fc, m_cyc + 32'd3});
      if (ifl) begin
        d_valid = 0;
      end else begin
        d_valid = 1;
        d_tag   = m_tag;
        d_pc    = fetch_pc;
        d_instr = fetch_instr;
        d_fc    = m_cyc;
        m_tag   = m_tag + 1'b1;
      end
    end
    m_cyc = m_cyc + 1;
  endtask

  task automatic step(input bit st, input bit ifl, input bit idf, input bit rdy, input bit r);
    stall       = st;
    if_flush    = ifl;
    id_flush    = idf;
    trace_ready = rdy;
    rst         = r;
    check_outputs();
    model_edge(st, ifl, idf, rdy, r);
    if (r) pc_reg = '0;
    else if (!st) pc_reg = pc_reg + 16'd2;
    @(negedge clk);
    fetch_pc = pc_reg;
    if (!st || r) fetch_instr = 16'($urandom);
  endtask

  task automatic plain(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 0, 0, rdy, 0);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 1, 0, rdy, 0);
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 1);
    log_tag.delete();
    log_pc.delete();
    log_delta.delete();
    first_valid = -1;
  endtask

  initial begin
    rst         = 1'b1;
    stall       = 1'b0;
    if_flush    = 1'b0;
    id_flush    = 1'b0;
    trace_ready = 1'b0;
    fetch_pc    = '0;
    fetch_instr = 16'($urandom);
    pc_reg      = '0;
    first_valid = -1;
    model_edge(0, 0, 0, 0, 1);
    @(negedge clk);

    // Straight line: six fetches, then bubbles
    do_reset();
    plain(6, 1);
    idle(10, 1);
    chk("straight_count", 128'(log_tag.size()), 128'(6));
    chk("straight_first_valid", 128'(first_valid), 128'(5));
    for (int i = 0; i < 6; i++) begin
      chk("straight_tag", 128'(log_tag[i]), 128'(i));
      chk("straight_pc", 128'(log_pc[i]), 128'(2 * i));
      chk("straight_delta", 128'(log_delta[i]), 128'(4));
    end

    // One stall cycle while tag 2 sits in ID
    do_reset();
    plain(3, 1);
    step(1, 0, 0, 1, 0);
    plain(3, 1);
    idle(10, 1);
    chk("stall_count", 128'(log_tag.size()), 128'(6));
    for (int i = 0; i < 6; i++) begin
      chk("stall_tag", 128'(log_tag[i]), 128'(i));
      chk("stall_delta", 128'(log_delta[i]), 128'((i == 2) ? 5 : 4));
    end

    // if_flush with PC 0x0006 in IF
    do_reset();
    plain(3, 1);
    step(0, 1, 0, 1, 0);
    plain(2, 1);
    idle(10, 1);
    chk("flush_count", 128'(log_tag.size()), 128'(5));
    chk("flush_pc_after", 128'(log_pc[3]), 128'(16'h0008));
    chk("flush_tag_after", 128'(log_tag[3]), 128'(3));
    chk("flush_pc_last", 128'(log_pc[4]), 128'(16'h000A));

    // stall together with if_flush: ID holds tag 1
    do_reset();
    plain(2, 1);
    step(1, 1, 0, 1, 0);
    plain(2, 1);
    idle(10, 1);
    chk("stflush_count", 128'(log_tag.size()), 128'(4));
    for (int i = 0; i < 4; i++) chk("stflush_tag", 128'(log_tag[i]), 128'(i));
    chk("stflush_delta_held", 128'(log_delta[1]), 128'(5));

    // Backpressure: twelve records into an eight-deep FIFO
    do_reset();
    plain(12, 0);
    idle(8, 0);
    chk("bp_fifo_count", 128'(fifo_count), 128'(8));
    chk("bp_overflow", 128'(overflow_cnt), 128'(4));
    idle(12, 1);
    chk("bp_drain_count", 128'(log_tag.size()), 128'(8));
    for (int i = 0; i < 8; i++) chk("bp_drain_tag", 128'(log_tag[i]), 128'(i));

    // Tag wrap across 130 instructions
    do_reset();
    plain(130, 1);
    idle(10, 1);
    chk("wrap_count", 128'(log_tag.size()), 128'(130));
    for (int i = 0; i < 130; i++) begin
      chk("wrap_tag", 128'(log_tag[i]), 128'(i % 128));
      chk("wrap_pc", 128'(log_pc[i]), 128'((2 * i) % 65536));
    end

    // Reset with three in flight and two queued
    do_reset();
    plain(5, 0);
    idle(1, 0);
    chk("midrst_queued", 128'(fifo_count), 128'(2));
    do_reset();
    chk("midrst_valid", 128'(trace_valid), 128'(0));
    plain(3, 1);
    idle(10, 1);
    chk("midrst_count", 128'(log_tag.size()), 128'(3));
    for (int i = 0; i < 3; i++) begin
      chk("midrst_tag", 128'(log_tag[i]), 128'(i));
      chk("midrst_pc", 128'(log_pc[i]), 128'(2 * i));
    end

    // Randomized controls against the reference
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0, 0);
    end
    idle(20, 1);
    check_outputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
